addr_sequencer: RTL

- Parametrised memory-address sequencer for the find-max datapath; replaces the fixed 8-bit up-counter.
- Issues `count` addresses starting at `start_addr`, with a programmable stride and direction.
- Uses a ready/valid stream toward the memory/compare stage, so the consumer can stall it.
- Supports a start/busy/done command handshake, abort, and a beat index so the max-finder can record the location of the maximum.

---
 rtl/addr_seq_pkg.sv | 14 +
 rtl/addr_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/addr_seq_pkg.sv
// Shared constants for the find-max address sequencer.
// State encoding is fixed so other blocks and debug tooling can decode it.
package addr_seq_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/addr_sequencer.sv
// Strided address sequencer feeding the find-max compare stage over ready/valid.
// Supports start/busy/done, abort, and a beat index for locating the maximum.
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 8,
  parameter int STRIDE_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [CNT_W-1:0]    count_i,
  input  logic [STRIDE_W-1:0] stride_i,
  input  logic                dir_i,
  input  logic                abort_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [CNT_W-1:0]    idx_o,
  output logic                addr_valid_o,
  input  logic                addr_ready_i,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o
);

  // FSM states:
  //   IDLE   | waiting for start; addr/idx hold their last values
  //   RUN    | issuing addresses, one per handshake
  //   FINISH | one-cycle done pulse, then back to IDLE

  state_t                state_q,   state_d;
  logic [ADDR_W-1:0]     addr_q,    addr_d;
  logic [CNT_W-1:0]      idx_q,     idx_d;
  logic                  last_q,    last_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic [STRIDE_W-1:0]   stride_q,  stride_d;
  logic                  dir_q,     dir_d;
  logic                  aborted_q, aborted_d;

  logic                  handshake;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [CNT_W-1:0]      idx_nxt;

  assign handshake = (state_q == RUN) && addr_ready_i;
  assign addr_nxt  = (dir_q == DIR_DOWN) ? (addr_q - ADDR_W'(stride_q))
                                         : (addr_q + ADDR_W'(stride_q));
  assign idx_nxt   = idx_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    last_d    = last_q;
    count_d   = count_q;
    stride_d  = stride_q;
    dir_d     = dir_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            count_d  = count_i;
            stride_d = stride_i;
            dir_d    = dir_i;
            addr_d   = start_addr_i;
            idx_d    = '0;
            last_d   = (count_i == CNT_W'(1));
            state_d  = RUN;
          end else begin
            state_d  = FINISH;
          end
        end
      end
      RUN: begin
        // A final handshake takes priority over a coincident abort.
        if (handshake && last_q) begin
          state_d = FINISH;
        end else if (abort_i) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (handshake) begin
          addr_d = addr_nxt;
          idx_d  = idx_nxt;
          last_d = (idx_nxt == (count_q - CNT_W'(1)));
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      count_q   <= '0;
      stride_q  <= '0;
      dir_q     <= DIR_UP;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      count_q   <= count_d;
      stride_q  <= stride_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

  assign addr_o       = addr_q;
  assign idx_o        = idx_q;
  assign addr_valid_o = (state_q == RUN);
  assign busy_o       = (state_q == RUN);
  assign last_o       = last_q && (state_q == RUN);
  assign done_o       = (state_q == FINISH);
  assign aborted_o    = aborted_q;

endmodule
